// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN         = 32;

  typedef struct packed {
    logic [ILEN-1:0]         inst;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO: registered storage, combinational head read,
// synchronous flush that wins over push/pop.
module sync_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok, push_ok;

  // Guard against underflow/overflow even if the caller misbehaves.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok) && !flush_i;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads to a 1-cycle memory and
// buffers responses, with credit-based flow control and flush-on-redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned         XLEN     = XLEN_DEFAULT,
  parameter  int unsigned         DEPTH    = 4,
  parameter  logic [XLEN-1:0]     RESET_PC = '0,
  localparam int unsigned         CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_dout,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [ILEN-1:0] deq_inst,
  output logic [XLEN-1:0] deq_pc,
  output logic [CW-1:0]   count
);

  localparam int unsigned EW = ILEN + XLEN;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic            pending_q, pending_d;
  logic            deq_fire, push;
  logic [CW:0]     committed;
  logic [EW-1:0]   head;

  assign deq_fire  = deq_valid && deq_ready;
  // Queued + in-flight entries after this edge's dequeue must leave a free slot.
  assign committed = (CW+1)'(count) + (CW+1)'(pending_q) - (CW+1)'(deq_fire);
  assign imem_en   = rst && !redirect_valid && (committed < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign push      = pending_q && !redirect_valid;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    pending_d    = imem_en;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (imem_en) begin
      fetch_pc_d   = fetch_pc_q + XLEN'(4);
      pending_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      pending_q    <= pending_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({imem_dout, pending_pc_q}),
    .pop_i   (deq_fire),
    .rdata_o (head),
    .count_o (count)
  );

  assign deq_valid = (count != '0);
  assign deq_inst  = head[EW-1 -: ILEN];
  assign deq_pc    = head[XLEN-1:0];

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, width of all PC/address signals.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 imem_en  output  1  instruction memory read enable.
REQ-007 imem_addr  output  XLEN  read address, byte-addressed.
REQ-008 imem_dout  input  32  read data, valid one cycle after an enabled edge.
REQ-009 redirect_valid  input  1  flush-and-redirect request.
REQ-010 redirect_pc  input  XLEN  new fetch address.
REQ-011 deq_valid  output  1  head entry valid.
REQ-012 deq_ready  input  1  consumer accepts head.
REQ-013 deq_inst  output  32  head instruction word.
REQ-014 deq_pc  output  XLEN  head instruction PC.
REQ-015 count  output  clog2(DEPTH)+1  entries currently queued.

Function
REQ-016 fetch_pc register holds the next address; imem_addr SHALL equal fetch_pc combinationally.
REQ-017 deq_fire = deq_valid && deq_ready; in-flight pending flag = read issued last edge and not killed.
REQ-018 imem_en = !redirect_valid && (count + pending - deq_fire < DEPTH); fetch_pc advances by 4 on each edge where imem_en is high.
REQ-019 An edge with imem_en high sets pending and records fetch_pc as pending_pc; otherwise pending clears.
REQ-020 When pending is set, the next edge writes {imem_dout, pending_pc} at the tail.
REQ-021 Fetch-to-dequeue latency: an address issued at edge N SHALL be visible at the head after edge N+1.
REQ-022 Sustained throughput SHALL be one instruction per cycle while deq_ready is held high, for any legal DEPTH.
REQ-023 Simultaneous enqueue and deq_fire leave count unchanged; the queue SHALL never overflow or underflow.
REQ-024 deq_inst and deq_pc are don't-care while deq_valid is low; head order is FIFO.
REQ-025 Redirect edge: a deq_fire in that cycle completes; the queue is emptied, pending is killed, and fetch_pc is loaded with {redirect_pc[XLEN-1:2], 2'b00}.
REQ-026 A response arriving in the cycle after a redirect SHALL be discarded.
REQ-027 Back-to-back redirects: the last one wins; no fetch is issued while redirect_valid is high.
REQ-028 Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.

Reset
REQ-029 While rst is low: fetch_pc = RESET_PC, pending = 0, pointers = 0, count = 0, deq_valid = 0, imem_en = 0.
REQ-030 First edge after rst rises SHALL issue RESET_PC.
REQ-031 Reset asserted mid-operation discards all queued and in-flight data immediately (asynchronous).

Structure
REQ-032 XLEN default, instruction width 32, and the fetch-entry packed struct {inst, pc} SHALL live in shared package fetch_pkg.
REQ-033 Storage SHALL be one sub-module, sync_fifo (parametrised WIDTH/DEPTH, registered array, combinational head read).
REQ-034 Control (pending, credit, redirect) SHALL stay in fetch_queue.

Verification
REQ-035 Memory model: synchronous ROM returning 32'h1000_0000 | addr; rst released, deq_ready=1 -> deq_pc 0,4,8,... on consecutive cycles, first deq_valid two edges after release.
REQ-036 deq_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, imem_en low, no entry lost, then drain yields PCs 0,4,8,12 in order.
REQ-037 Redirect to 32'h0000_0103 while queue holds 3 entries -> count 0 next cycle, next deq_pc = 32'h100, no stale word 32'h1000_000C appears.
REQ-038 Redirect in same cycle as deq_fire -> that head is consumed once, queue then empty.
REQ-039 rst pulsed low for 3 ns between edges while full -> deq_valid drops immediately; refetch restarts at RESET_PC.
REQ-040 Repeat REQ-035/036 with DEPTH=2 and DEPTH=8 -> full throughput, count never exceeds DEPTH.
